// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: centre-samples each bit on the fabric clock and hands bytes
// downstream over valid/ready, with one-cycle framing-error and overrun pulses.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Handshake: a byte is transferred in any cycle where rx_valid and rx_ready are
    // both 1; rx_data is stable while rx_valid is 1 and changes only when a byte loads.

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            rx_m;
    logic            rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Accept clears valid; a load in the same cycle below overrides this.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Leave mid stop bit so a back-to-back start edge is caught.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: a fast instance (16 clocks/bit) for protocol cases
// and a 1250 clocks/bit instance for baud drift and mid-frame reset.
module tb_uart_rx_8n1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       rx_a = 1'b1;
    logic       ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, fe_a, ov_a, busy_a;

    logic       rx_b = 1'b1;
    logic       ready_b = 1'b1;
    logic [7:0] data_b;
    logic       valid_b, fe_b, ov_b, busy_b;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];

    int cyc = 0;
    int vcnt_a = 0, fecnt_a = 0, ovcnt_a = 0, start_cyc_a = 0, vrise_cyc_a = 0;
    logic vq_a = 1'b0, bq_a = 1'b0;
    int vcnt_b = 0, fecnt_b = 0, ovcnt_b = 0;

    uart_rx_8n1 #(.CLKS_PER_BIT(16)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(1250)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // passive monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_a) vcnt_a <= vcnt_a + 1;
        if (valid_a && !vq_a) vrise_cyc_a <= cyc;
        if (busy_a && !bq_a) start_cyc_a <= cyc;
        if (valid_a && ready_a) got_a.push_back(data_a);
        if (fe_a) fecnt_a <= fecnt_a + 1;
        if (ov_a) ovcnt_a <= ovcnt_a + 1;
        vq_a <= valid_a;
        bq_a <= busy_a;
        if (valid_b) vcnt_b <= vcnt_b + 1;
        if (valid_b && ready_b) got_b.push_back(data_b);
        if (fe_b) fecnt_b <= fecnt_b + 1;
        if (ov_b) ovcnt_b <= ovcnt_b + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input int t, input logic stop);
        set_line(sel, 1'b0);
        hold(t);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            hold(t);
        end
        set_line(sel, stop);
        hold(t);
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_a(input string tag);
        check({tag, "_count"}, got_a.size(), exp_q.size());
        while (got_a.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, {24'h0, got_a.pop_front()}, {24'h0, exp_q.pop_front()});
        got_a.delete();
        exp_q.delete();
    endtask

    task automatic sb_b(input string tag);
        check({tag, "_count"}, got_b.size(), exp_q.size());
        while (got_b.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, {24'h0, got_b.pop_front()}, {24'h0, exp_q.pop_front()});
        got_b.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0, fe0, ov0;

        // reset state
        hold(4);
        check("rst_data", {24'h0, data_a}, 32'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_fe", fe_a, 1'b0);
        check("rst_ov", ov_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        rst = 1'b0;
        hold(5);

        // single byte, consumer always ready
        v0 = vcnt_a; fe0 = fecnt_a; ov0 = ovcnt_a;
        exp_q.push_back(8'h44);
        send(1'b0, 8'h44, 16, 1'b1);
        hold(10);
        sb_a("single");
        check("single_latency", vrise_cyc_a - start_cyc_a, 8 + 9 * 16);
        check("single_valid_len", vcnt_a - v0, 1);
        check("single_flags", (fecnt_a - fe0) + (ovcnt_a - ov0), 0);

        // back-to-back frames with the consumer stalled
        ready_a = 1'b0;
        ov0 = ovcnt_a; fe0 = fecnt_a;
        send(1'b0, 8'hA5, 16, 1'b1);
        send(1'b0, 8'h3C, 16, 1'b1);
        hold(8);
        check("b2b_valid_held", valid_a, 1'b1);
        check("b2b_data_held", {24'h0, data_a}, 32'hA5);
        check("b2b_overrun_once", ovcnt_a - ov0, 1);
        check("b2b_no_fe", fecnt_a - fe0, 0);
        ready_a = 1'b1;
        hold(1);
        check("b2b_valid_drop", valid_a, 1'b0);
        exp_q.push_back(8'hA5);
        sb_a("b2b");

        // framing error, then line held low
        v0 = vcnt_a; fe0 = fecnt_a; ov0 = ovcnt_a;
        send(1'b0, 8'hFF, 16, 1'b0);
        hold(40 * 16);
        check("fe_pulse_once", fecnt_a - fe0, 1);
        check("fe_no_valid", vcnt_a - v0, 0);
        check("fe_no_ov", ovcnt_a - ov0, 0);
        check("fe_busy_break", busy_a, 1'b1);
        rx_a = 1'b1;
        hold(4);
        check("fe_release_idle", busy_a, 1'b0);

        // glitch shorter than half a bit
        v0 = vcnt_a; fe0 = fecnt_a; ov0 = ovcnt_a;
        rx_a = 1'b0;
        hold(4);
        check("glitch_busy_seen", busy_a, 1'b1);
        hold(2);
        rx_a = 1'b1;
        hold(20);
        check("glitch_idle", busy_a, 1'b0);
        check("glitch_no_events", (vcnt_a - v0) + (fecnt_a - fe0) + (ovcnt_a - ov0), 0);

        // baud drift at 1250 clocks/bit: slow sender, then fast sender
        exp_q.push_back(8'h55);
        send(1'b1, 8'h55, 1288, 1'b1);
        hold(100);
        sb_b("drift_slow");
        ready_b = 1'b0;
        send(1'b1, 8'h55, 1212, 1'b1);
        hold(100);
        check("drift_fast_valid", valid_b, 1'b1);
        check("drift_fast_data", {24'h0, data_b}, 32'h55);
        check("drift_flags", fecnt_b + ovcnt_b, 0);

        // reset mid-DATA clears held byte and abandons the frame
        rx_b = 1'b0;
        hold(1250);
        rx_b = 1'b1;
        hold(2500);
        check("pre_rst_busy", busy_b, 1'b1);
        rst = 1'b1;
        hold(1);
        check("mid_rst_data", {24'h0, data_b}, 32'h00);
        check("mid_rst_valid", valid_b, 1'b0);
        check("mid_rst_busy", busy_b, 1'b0);
        check("mid_rst_flags", {fe_b, ov_b}, 2'b00);
        rst = 1'b0;
        ready_b = 1'b1;
        hold(50);
        exp_q.push_back(8'hC3);
        send(1'b1, 8'hC3, 1250, 1'b1);
        hold(100);
        sb_b("post_rst");
        check("post_rst_flags", fecnt_b + ovcnt_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
